// File: rtl/bcd3_entry_ctrl.sv
// Digit-serial operand entry, settle timing and result capture for the 3-digit BCD adder.
// Optional BCD3_CARRY_CHAIN_EN: feed each consumed carry-out back as the next carry-in.
module bcd3_entry_ctrl #(
  parameter int unsigned SETTLE_CYC = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_digit,
  input  logic        in_enter,
  input  logic        in_clear,
  output logic [11:0] add_m,
  output logic [11:0] add_n,
  output logic        add_p,
  input  logic [11:0] add_q,
  input  logic        add_w,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [11:0] res_q,
  output logic        res_w,
  output logic        err
);

  localparam int unsigned DW = 4;
  localparam int unsigned OW = 12;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {ENTRY_A, ENTRY_B, SETTLE, DONE} state_e;

  state_e        state_q, state_d;
  logic [OW-1:0] op_a_q, op_a_d;
  logic [OW-1:0] op_b_q, op_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          err_q, err_d;
`ifdef BCD3_CARRY_CHAIN_EN
  logic          carry_q, carry_d;
`endif

  logic beat_acc;
  logic digit_ok;

  assign beat_acc = in_valid && in_ready;
  assign digit_ok = (in_digit <= DW'(9));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ENTRY_A;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD3_CARRY_CHAIN_EN
      carry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
`ifdef BCD3_CARRY_CHAIN_EN
      carry_q <= carry_d;
`endif
    end
  end

  // Next-state and datapath update; clear overrides everything, including a same-cycle beat
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = 1'b0;
`ifdef BCD3_CARRY_CHAIN_EN
    carry_d = carry_q;
`endif
    if (in_clear) begin
      state_d = ENTRY_A;
      op_a_d  = '0;
      op_b_d  = '0;
      cnt_d   = '0;
`ifdef BCD3_CARRY_CHAIN_EN
      carry_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ENTRY_A: begin
          if (beat_acc) begin
            if (in_enter)      state_d = ENTRY_B;
            else if (digit_ok) op_a_d  = {op_a_q[OW-DW-1:0], in_digit};
            else               err_d   = 1'b1;
          end
        end
        ENTRY_B: begin
          if (beat_acc) begin
            if (in_enter) begin
              state_d = SETTLE;
              cnt_d   = CW'(SETTLE_CYC - 1);
            end else if (digit_ok) begin
              op_b_d = {op_b_q[OW-DW-1:0], in_digit};
            end else begin
              err_d = 1'b1;
            end
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            sum_d   = add_q;
            cout_d  = add_w;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            op_a_d  = '0;
            op_b_d  = '0;
            state_d = ENTRY_A;
`ifdef BCD3_CARRY_CHAIN_EN
            carry_d = cout_q;
`endif
          end
        end
        default: state_d = ENTRY_A;
      endcase
    end
  end

  // Outputs: pure decodes of registered state
  always_comb begin
    in_ready  = (state_q == ENTRY_A) || (state_q == ENTRY_B);
    res_valid = (state_q == DONE);
    add_m     = op_a_q;
    add_n     = op_b_q;
    res_q     = sum_q;
    res_w     = cout_q;
    err       = err_q;
`ifdef BCD3_CARRY_CHAIN_EN
    add_p     = carry_q;
`else
    add_p     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bcd3_entry_ctrl.sv
// Directed bench for bcd3_entry_ctrl with a behavioural 3-digit BCD adder on M/N/p.
module tb_bcd3_entry_ctrl;

  localparam int unsigned SC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_enter, in_clear;
  logic [3:0]  in_digit;
  logic [11:0] add_m, add_n, add_q;
  logic        add_p, add_w;
  logic        res_valid, res_ready, res_w, err;
  logic [11:0] res_q;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bcd3_entry_ctrl #(.SETTLE_CYC(SC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit),
    .in_enter(in_enter), .in_clear(in_clear),
    .add_m(add_m), .add_n(add_n), .add_p(add_p),
    .add_q(add_q), .add_w(add_w),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_q(res_q), .res_w(res_w), .err(err)
  );

  // External adder: digit-wise decimal ripple
  function automatic logic [12:0] bcd_add(input logic [11:0] m, input logic [11:0] n, input logic p);
    logic [12:0] r;
    logic        c;
    int          s;
    r = '0;
    c = p;
    for (int i = 0; i < 3; i++) begin
      s = int'(m[i*4 +: 4]) + int'(n[i*4 +: 4]) + int'(c);
      c = (s > 9);
      if (c) s = s - 10;
      r[i*4 +: 4] = 4'(s);
    end
    r[12] = c;
    return r;
  endfunction

  assign {add_w, add_q} = bcd_add(add_m, add_n, add_p);

`ifdef BCD3_CARRY_CHAIN_EN
  localparam logic CHAIN = 1'b1;
`else
  localparam logic CHAIN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic beat(input logic [3:0] d, input logic ent);
    @(negedge clk);
    in_valid = 1'b1;
    in_digit = d;
    in_enter = ent;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_enter = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic consume();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
  endtask

  task automatic clear_with_beat(input logic [3:0] d);
    @(negedge clk);
    in_clear = 1'b1;
    in_valid = 1'b1;
    in_digit = d;
    @(posedge clk);
    #1;
    in_clear = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_digit = '0; in_enter = 1'b0;
    in_clear = 1'b0; res_ready = 1'b0;
    #12;
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_add_m", 16'(add_m), 16'h0);
    chk("rst_add_n", 16'(add_n), 16'h0);
    chk("rst_add_p", 16'(add_p), 16'h0);
    chk("rst_res_valid", 16'(res_valid), 16'h0);
    chk("rst_res_q", 16'(res_q), 16'h0);
    chk("rst_res_w", 16'(res_w), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add 123 + 456
    beat(4'd1, 1'b0); beat(4'd2, 1'b0); beat(4'd3, 1'b0);
    chk("basic_add_m", 16'(add_m), 16'h123);
    beat(4'd0, 1'b1);
    beat(4'd4, 1'b0); beat(4'd5, 1'b0); beat(4'd6, 1'b0);
    chk("basic_add_n", 16'(add_n), 16'h456);
    beat(4'd0, 1'b1);
    chk("settle_in_ready", 16'(in_ready), 16'h0);
    // Offer beats throughout SETTLE; they must not be taken
    in_valid = 1'b1; in_digit = 4'd7;
    for (int i = 1; i < int'(SC); i++) begin
      chk("settle_res_valid", 16'(res_valid), 16'h0);
      chk("settle_add_m", 16'(add_m), 16'h123);
      chk("settle_add_n", 16'(add_n), 16'h456);
      tick();
    end
    chk("settle_last_res_valid", 16'(res_valid), 16'h0);
    tick();
    chk("basic_res_valid", 16'(res_valid), 16'h1);
    chk("basic_res_q", 16'(res_q), 16'h579);
    chk("basic_res_w", 16'(res_w), 16'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_res_valid", 16'(res_valid), 16'h1);
      chk("hold_res_q", 16'(res_q), 16'h579);
      chk("hold_add_m", 16'(add_m), 16'h123);
    end
    in_valid = 1'b0;
    consume();
    chk("consume_in_ready", 16'(in_ready), 16'h1);
    chk("consume_res_valid", 16'(res_valid), 16'h0);
    chk("consume_add_m", 16'(add_m), 16'h0);
    chk("consume_add_n", 16'(add_n), 16'h0);

    // Carry out 999 + 001
    beat(4'd9, 1'b0); beat(4'd9, 1'b0); beat(4'd9, 1'b0); beat(4'd0, 1'b1);
    beat(4'd0, 1'b0); beat(4'd0, 1'b0); beat(4'd1, 1'b0); beat(4'd0, 1'b1);
    repeat (SC) tick();
    chk("carry_res_valid", 16'(res_valid), 16'h1);
    chk("carry_res_q", 16'(res_q), 16'h000);
    chk("carry_res_w", 16'(res_w), 16'h1);
    consume();
    chk("chain_add_p", 16'(add_p), 16'(CHAIN));
    beat(4'd0, 1'b1); beat(4'd0, 1'b1);
    repeat (SC) tick();
    chk("chain_res_valid", 16'(res_valid), 16'h1);
    chk("chain_res_q", 16'(res_q), CHAIN ? 16'h001 : 16'h000);
    chk("chain_res_w", 16'(res_w), 16'h0);
    consume();
    chk("chain_add_p_after", 16'(add_p), 16'h0);

    // Overflow entry and rejected digit
    beat(4'd1, 1'b0); beat(4'd2, 1'b0); beat(4'd3, 1'b0); beat(4'd4, 1'b0);
    chk("ovf_add_m", 16'(add_m), 16'h234);
    chk("ovf_err_idle", 16'(err), 16'h0);
    beat(4'hB, 1'b0);
    chk("bad_err", 16'(err), 16'h1);
    chk("bad_add_m", 16'(add_m), 16'h234);
    chk("bad_in_ready", 16'(in_ready), 16'h1);
    tick();
    chk("bad_err_drop", 16'(err), 16'h0);

    // Clear in ENTRY_A drops the simultaneous digit
    clear_with_beat(4'd8);
    chk("clr_entry_add_m", 16'(add_m), 16'h0);
    chk("clr_entry_err", 16'(err), 16'h0);

    // Clear in SETTLE
    beat(4'd7, 1'b0); beat(4'd0, 1'b1); beat(4'd5, 1'b0); beat(4'd0, 1'b1);
    tick();
    clear_with_beat(4'd3);
    chk("clr_settle_in_ready", 16'(in_ready), 16'h1);
    chk("clr_settle_res_valid", 16'(res_valid), 16'h0);
    chk("clr_settle_add_m", 16'(add_m), 16'h0);
    chk("clr_settle_add_n", 16'(add_n), 16'h0);
    repeat (SC + 1) tick();
    chk("clr_settle_stays_idle", 16'(res_valid), 16'h0);

    // Clear in DONE
    beat(4'd2, 1'b0); beat(4'd0, 1'b1); beat(4'd3, 1'b0); beat(4'd0, 1'b1);
    repeat (SC) tick();
    chk("done_res_valid", 16'(res_valid), 16'h1);
    chk("done_res_q", 16'(res_q), 16'h005);
    clear_with_beat(4'd6);
    chk("clr_done_res_valid", 16'(res_valid), 16'h0);
    chk("clr_done_in_ready", 16'(in_ready), 16'h1);
    chk("clr_done_add_m", 16'(add_m), 16'h0);
    chk("clr_done_add_n", 16'(add_n), 16'h0);

    // Async reset mid-SETTLE
    beat(4'd1, 1'b0); beat(4'd0, 1'b1); beat(4'd1, 1'b0); beat(4'd0, 1'b1);
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 16'(in_ready), 16'h1);
    chk("arst_add_m", 16'(add_m), 16'h0);
    chk("arst_add_n", 16'(add_n), 16'h0);
    chk("arst_res_valid", 16'(res_valid), 16'h0);
    chk("arst_res_q", 16'(res_q), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(4'd4, 1'b0); beat(4'd0, 1'b1); beat(4'd5, 1'b0); beat(4'd0, 1'b1);
    repeat (SC - 1) tick();
    chk("post_rst_not_yet", 16'(res_valid), 16'h0);
    tick();
    chk("post_rst_res_valid", 16'(res_valid), 16'h1);
    chk("post_rst_res_q", 16'(res_q), 16'h009);
    consume();
    chk("post_rst_in_ready", 16'(in_ready), 16'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bcd3_entry_ctrl.md
# bcd3_entry_ctrl

Sequential front-end for the 3-digit BCD parallel adder. It collects two 3-digit BCD operands one digit at a time over a valid/ready handshake and drives them, with carry-in, onto the adder's M/N/p inputs. It holds them stable for a programmable settle window that covers the adder's worst-case ripple, then captures Q/w into a result register. The result is offered downstream over a second valid/ready handshake.

## Interface
- SETTLE_CYC, default 100: clock cycles operands are held before Q/w are sampled. Range 1..255. 100 at a 10 ns clock covers the 875 ns worst case.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset. One clock domain; reset is asynchronous and active-low.
- in_valid  in  1  entry beat offered.
- in_ready  out  1  entry beat accepted when in_valid & in_ready.
- in_digit  in  4  BCD digit, 0..9.
- in_enter  in  1  beat is an ENTER command; in_digit is ignored.
- in_clear  in  1  synchronous abort and clear, any state.
- add_m  out  12  operand A to adder M.
- add_n  out  12  operand B to adder N.
- add_p  out  1  adder carry-in p.
- add_q  in  12  adder sum Q.
- add_w  in  1  adder carry-out w.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_q  out  12  captured sum, 3 BCD digits.
- res_w  out  1  captured decimal carry.
- err  out  1  one-cycle pulse: rejected digit (>9).

## Operation
- States:
  - ENTRY_A: beats build operand A.
  - ENTRY_B: beats build operand B.
  - SETTLE: operands held while the counter runs.
  - DONE: result is being offered.
- Digit beat (in_enter=0, in_digit<=9): the operand shifts left one digit and the new digit enters [3:0]. The oldest digit [11:8] is discarded.
- Digit beat with in_digit>9: the beat is still accepted (consumed). The operand is unchanged and err pulses for 1 cycle.
- ENTER beat:
  - ENTRY_A → ENTRY_B.
  - ENTRY_B → SETTLE; the counter loads SETTLE_CYC-1.
  - Zero-digit operands are legal (value 000).
- SETTLE:
  - Counter decrements each cycle.
  - At the edge where the count is 0: res_q←add_q, res_w←add_w, state → DONE.
  - add_m/add_n/add_p stay constant for the entire window.
- DONE: res_valid=1; res_q/res_w are stable. On res_valid & res_ready: both operands clear to 0, state → ENTRY_A.
- in_clear (highest priority, any state): next edge gives state ENTRY_A, operands 0, res_valid 0, counter 0, carry store 0. Any beat presented in the same cycle is dropped. No err pulse.
- add_m/add_n are driven directly from the operand registers. They change only on accepted digit beats, clear, or result consumption.

## Timing
- Reset values: in_ready 1, add_m 0, add_n 0, add_p 0, res_valid 0, res_q 0, res_w 0, err 0, state ENTRY_A.
- in_ready = 1 in ENTRY_A/ENTRY_B, 0 in SETTLE/DONE. It is a decode of the state register only, with no combinational path from inputs.
- Beat accepted at edge k: the operand update is visible after edge k.
- ENTER in ENTRY_B accepted at edge k: res_valid rises after edge k+SETTLE_CYC. SETTLE_CYC=1 samples at edge k+1.
- res_valid held until the handshake. Result consumed at edge j: in_ready=1 after edge j.
- err is registered: high for exactly the cycle after the rejecting edge.
- Reset mid-SETTLE or mid-DONE: the result is discarded, all outputs return to reset values asynchronously.

## Configuration
- BCD3_CARRY_CHAIN_EN defined:
  - A 1-bit carry store captures res_w when a result is consumed.
  - add_p = carry store, for multi-precision chaining of successive additions.
  - The store is cleared by reset and in_clear.
- Undefined: add_p tied 0, no carry store.

## Test plan
- Basic add, SETTLE_CYC=4: digits 1,2,3,ENTER,4,5,6,ENTER → add_m=0x123, add_n=0x456. res_valid 4 cycles after the second ENTER; res_q=0x579, res_w=0. Hold res_ready=0 for 10 cycles; values must stay stable.
- Carry: 9,9,9,ENTER,0,0,1,ENTER → res_q=0x000, res_w=1. With BCD3_CARRY_CHAIN_EN, the next 0+0 operation has add_p=1 and gives res_q=0x001. Without it, add_p=0 and res_q=0x000.
- Overflow entry: 1,2,3,4 → add_m=0x234. Digit 0xB → err pulses once, add_m unchanged, beat consumed (in_ready stays 1).
- Handshake: in_valid asserted during SETTLE/DONE → no operand change. Operands must be held constant for every cycle of SETTLE.
- in_clear asserted in SETTLE and separately in DONE → state ENTRY_A, res_valid 0, add_m=add_n=0. A simultaneous digit beat is ignored.
- Async reset pulse mid-SETTLE → all outputs reach reset values before the next clock edge. After release, a full operation completes correctly.
